// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM state encoding and default frame geometry.
// The defaults are also used by the TX path and the baud generator.
package uart_pkg;

    localparam int unsigned DEF_OVERSAMPLING_RATE = 8;
    localparam int unsigned DEF_DATA_BITS         = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Generic 2-flop synchroniser for a single asynchronous bit.
// Ports:
//   i_clk  in  1  destination clock
//   i_rst  in  1  synchronous active-high reset (both flops load RESET_VAL)
//   i_d    in  1  asynchronous input
//   o_q    out 1  synchronised output
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// Oversampling UART receiver. Synchronises the serial line, validates the start
// bit at its centre, centre-samples data LSB-first, checks the stop bit and
// presents each byte with a one-cycle valid pulse.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit after data).
// Ports:
//   clk_in           in   1          system clock
//   rst_in           in   1          synchronous active-high reset
//   sample_pulse_in  in   1          oversample tick from the baud generator
//   rx_in            in   1          asynchronous serial line, idle high
//   data_out         out  DATA_BITS  last good byte, LSB = first bit received
//   valid_out        out  1          1-clk pulse when data_out updates
//   frame_err_out    out  1          1-clk pulse when stop bit sampled low
//   parity_err_out   out  1          1-clk pulse on parity mismatch
//   busy_out         out  1          high while not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLING_RATE = DEF_OVERSAMPLING_RATE,
    parameter int unsigned DATA_BITS         = DEF_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 sample_pulse_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err_out,
    output logic                 parity_err_out,
    output logic                 busy_out
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLING_RATE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLING_RATE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLING_RATE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_e            r_state,    w_state_nxt;
    logic [TICK_W-1:0]    r_tick_cnt, w_tick_nxt;
    logic [BIT_W-1:0]     r_bit_cnt,  w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_rx_prev,  w_prev_nxt;
    logic [DATA_BITS-1:0] r_data,     w_data_nxt;
    logic                 r_valid,    w_valid_nxt;
    logic                 r_ferr,     w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bit,  w_par_nxt;
    logic                 r_perr,     w_perr_nxt;
`endif

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .i_clk (clk_in),
        .i_rst (rst_in),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

    // Next-state and output decode; everything advances only on a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_prev_nxt  = r_rx_prev;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par_bit;
        w_perr_nxt  = 1'b0;
`endif
        if (sample_pulse_in) begin
            case (r_state)
                RX_IDLE: begin
                    // A held-low line keeps r_rx_prev low, so a break never retriggers.
                    w_prev_nxt = w_rx_s;
                    if (r_rx_prev && !w_rx_s) begin
                        w_state_nxt = RX_START;
                        w_tick_nxt  = '0;
                    end
                end
                RX_START: begin
                    if (r_tick_cnt == HALF_LAST) begin
                        if (w_rx_s) begin
                            w_state_nxt = RX_IDLE;
                        end else begin
                            w_state_nxt = RX_DATA;
                            w_tick_nxt  = '0;
                            w_bit_nxt   = '0;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tick_nxt  = '0;
                        w_bit_nxt   = r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = RX_PARITY;
`else
                            w_state_nxt = RX_STOP;
`endif
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_par_nxt   = w_rx_s;
                        w_tick_nxt  = '0;
                        w_state_nxt = RX_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_W'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (r_tick_cnt == FULL_LAST) begin
                        w_tick_nxt  = '0;
                        w_prev_nxt  = w_rx_s;
                        w_state_nxt = RX_IDLE;
                        if (w_rx_s) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                            w_perr_nxt  = (r_par_bit != (^r_shift));
`endif
                        end else begin
                            w_ferr_nxt = 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = RX_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= RX_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_prev  <= 1'b1;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_rx_prev  <= w_prev_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_ferr     <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bit  <= w_par_nxt;
            r_perr     <= w_perr_nxt;
`endif
        end
    end

    assign data_out      = r_data;
    assign valid_out     = r_valid;
    assign frame_err_out = r_ferr;
    assign busy_out      = (r_state != RX_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_out = r_perr;
`else
    assign parity_err_out = 1'b0;
`endif

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OSR=8, 8 data bits, tick every clock (1 bit = 8 clk).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       sample_pulse_in;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       frame_err_out;
    logic       parity_err_out;
    logic       busy_out;

    int checks   = 0;
    int failures = 0;

    // Pulse monitor state (sampled on negedge, away from the active edge).
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_perr  = 0;
    time        t_valid = 0;
    time        t_valid_prev = 0;
    logic [7:0] d_last = 8'h00;
    logic [7:0] d_prev = 8'h00;
    logic       perr_at_valid = 1'b0;
    time        t_start = 0;

    uart_rx #(.OVERSAMPLING_RATE(8), .DATA_BITS(8)) dut (
        .clk_in          (clk),
        .rst_in          (rst_in),
        .sample_pulse_in (sample_pulse_in),
        .rx_in           (rx_in),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .frame_err_out   (frame_err_out),
        .parity_err_out  (parity_err_out),
        .busy_out        (busy_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out) begin
            n_valid++;
            t_valid_prev  = t_valid;
            t_valid       = $time;
            d_prev        = d_last;
            d_last        = data_out;
            perr_at_valid = parity_err_out;
        end
        if (frame_err_out)  n_ferr++;
        if (parity_err_out) n_perr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One frame: start, LSB-first data, optional parity, one stop bit of given level.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic use_par, input logic par_bit);
        t_start = $time;
        rx_in = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_clk(8);
        end
        if (use_par) begin
            rx_in = par_bit;
            wait_clk(8);
        end
        rx_in = stop_bit;
        wait_clk(8);
    endtask

    int nv0;
    int nf0;

    initial begin
        rst_in = 1'b1;
        sample_pulse_in = 1'b1;
        rx_in = 1'b1;
        wait_clk(3);
        check("rst_data",  32'(data_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_ferr",  32'(frame_err_out), 32'h0);
        check("rst_perr",  32'(parity_err_out), 32'h0);
        check("rst_busy",  32'(busy_out), 32'h0);
        rst_in = 1'b0;
        wait_clk(5);

        // 1: good frame 0x55
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        wait_clk(10);
        check("t1_nvalid",  32'(n_valid), 32'd1);
        check("t1_data",    32'(data_out), 32'h55);
        check("t1_nferr",   32'(n_ferr), 32'd0);
        check("t1_latency", 32'(t_valid - t_start), 32'd790);
        check("t1_busy",    32'(busy_out), 32'h0);

        // 2: 3-clk glitch, rejected at start-bit centre
        rx_in = 1'b0;
        wait_clk(3);
        rx_in = 1'b1;
        wait_clk(1);
        check("t2_busy_hi", 32'(busy_out), 32'h1);
        wait_clk(3);
        check("t2_busy_lo", 32'(busy_out), 32'h0);
        wait_clk(20);
        check("t2_nvalid", 32'(n_valid), 32'd1);
        check("t2_nferr",  32'(n_ferr), 32'd0);

        // 3: framing error followed by a held-low break
        send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
        wait_clk(40);
        check("t3_nferr",  32'(n_ferr), 32'd1);
        check("t3_nvalid", 32'(n_valid), 32'd1);
        check("t3_data",   32'(data_out), 32'h55);
        check("t3_busy_break", 32'(busy_out), 32'h0);
        rx_in = 1'b1;
        wait_clk(20);
        check("t3_busy_idle", 32'(busy_out), 32'h0);
        check("t3_nferr_after", 32'(n_ferr), 32'd1);

        // 4: back-to-back frames
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        wait_clk(10);
        check("t4_nvalid",  32'(n_valid), 32'd3);
        check("t4_first",   32'(d_prev), 32'h00);
        check("t4_data",    32'(data_out), 32'hFF);
        check("t4_spacing", 32'(t_valid - t_valid_prev), 32'd800);
        check("t4_nferr",   32'(n_ferr), 32'd1);

        // 5: reset during data bit 4, then a clean frame
        rx_in = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            wait_clk(8);
        end
        rx_in = 1'b1;
        wait_clk(4);
        check("t5_busy_pre", 32'(busy_out), 32'h1);
        rst_in = 1'b1;
        rx_in = 1'b1;
        wait_clk(1);
        rst_in = 1'b0;
        check("t5_rst_data",  32'(data_out), 32'h0);
        check("t5_rst_valid", 32'(valid_out), 32'h0);
        check("t5_rst_ferr",  32'(frame_err_out), 32'h0);
        check("t5_rst_busy",  32'(busy_out), 32'h0);
        nv0 = n_valid;
        nf0 = n_ferr;
        wait_clk(100);
        check("t5_no_pulse_v", 32'(n_valid), 32'(nv0));
        check("t5_no_pulse_f", 32'(n_ferr), 32'(nf0));
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        wait_clk(10);
        check("t5_nvalid", 32'(n_valid), 32'(nv0 + 1));
        check("t5_data",   32'(data_out), 32'h3C);

`ifdef UART_RX_PARITY_EN
        // 6: even parity; 0x07 needs parity bit 1
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        wait_clk(10);
        check("t6_nvalid_a", 32'(n_valid), 32'(nv0 + 2));
        check("t6_data_a",   32'(data_out), 32'h07);
        check("t6_perr_a",   32'(perr_at_valid), 32'h1);
        check("t6_latency",  32'(t_valid - t_start), 32'd870);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        wait_clk(10);
        check("t6_nvalid_b", 32'(n_valid), 32'(nv0 + 3));
        check("t6_perr_b",   32'(perr_at_valid), 32'h0);
        check("t6_nperr",    32'(n_perr), 32'd1);
`else
        check("nperr_zero", 32'(n_perr), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx
